// File: rtl/carpma_birimi_hatli_if.sv
// Issue/result bundle between the execute-stage hazard logic and the pipelined multiplier.
// Handshake: an operation is taken when gecerli_i=1, durdur_i=0 and temizle_i=0; there is no ready,
// so the issuer holds its operation while durdur_i=1. gecerli_o marks one result per advancing cycle
// and simply holds (not a new result) while durdur_i=1.
interface carpma_birimi_hatli_if #(
  parameter int XLEN     = 32,
  parameter int ETIKET_W = 5
);
  logic                durdur_i;
  logic                temizle_i;
  logic                gecerli_i;
  logic [1:0]          kontrol_i;
  logic [XLEN-1:0]     deger1_i;
  logic [XLEN-1:0]     deger2_i;
  logic [ETIKET_W-1:0] etiket_i;
  logic [XLEN-1:0]     sonuc_o;
  logic                gecerli_o;
  logic [ETIKET_W-1:0] etiket_o;
  logic                mesgul_o;

  modport master (
    output durdur_i, temizle_i, gecerli_i, kontrol_i, deger1_i, deger2_i, etiket_i,
    input  sonuc_o, gecerli_o, etiket_o, mesgul_o
  );

  modport slave (
    input  durdur_i, temizle_i, gecerli_i, kontrol_i, deger1_i, deger2_i, etiket_i,
    output sonuc_o, gecerli_o, etiket_o, mesgul_o
  );
endinterface

// File: rtl/carpma_birimi_hatli.sv
// Fully pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU) with per-stage valid,
// tag pass-through, stall and flush. Latency is exactly ASAMA cycles; outputs come straight from flops.
module carpma_birimi_hatli #(
  parameter int XLEN     = 32,
  parameter int ASAMA    = 2,
  parameter int ETIKET_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  carpma_birimi_hatli_if.slave bus
);

  localparam logic [1:0] CARPMA_MUL    = 2'b00;
  localparam logic [1:0] CARPMA_MULH   = 2'b01;
  localparam logic [1:0] CARPMA_MULHSU = 2'b10;
  localparam logic [1:0] CARPMA_MULHU  = 2'b11;
  localparam int         PW            = 2 * XLEN + 2;

  function automatic logic [XLEN:0] genislet(input logic [XLEN-1:0] v, input logic isaretli);
    return {isaretli & v[XLEN-1], v};
  endfunction

  // Both operands are XLEN+1 signed, so one signed multiplier covers all four flavours.
  function automatic logic [2*XLEN-1:0] carp(input logic signed [XLEN:0] a,
                                             input logic signed [XLEN:0] b);
    logic signed [PW-1:0] p;
    p = a * b;
    return p[2*XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] sec(input logic [2*XLEN-1:0] p, input logic [1:0] op);
    return (op == CARPMA_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  logic ilerle;
  logic isaretli1;
  logic isaretli2;

  assign ilerle    = ~bus.durdur_i;
  assign isaretli1 = (bus.kontrol_i != CARPMA_MULHU);
  assign isaretli2 = (bus.kontrol_i == CARPMA_MUL) || (bus.kontrol_i == CARPMA_MULH);

  logic [ASAMA-1:0]    val_q, val_d;
  logic [1:0]          op_q [ASAMA];
  logic [1:0]          op_d [ASAMA];
  logic [ETIKET_W-1:0] etk_q[ASAMA];
  logic [ETIKET_W-1:0] etk_d[ASAMA];
  logic [XLEN-1:0]     sonuc_q, sonuc_d;

  // Control shift register; flush wins over stall so a mispredict kills work even while frozen.
  always_comb begin
    val_d = val_q;
    op_d  = op_q;
    etk_d = etk_q;
    if (ilerle) begin
      val_d[0] = bus.gecerli_i;
      op_d[0]  = bus.kontrol_i;
      etk_d[0] = bus.etiket_i;
      for (int i = 1; i < ASAMA; i++) begin
        val_d[i] = val_q[i-1];
        op_d[i]  = op_q[i-1];
        etk_d[i] = etk_q[i-1];
      end
    end
    if (bus.temizle_i) begin
      val_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_q   <= '0;
      op_q    <= '{default: '0};
      etk_q   <= '{default: '0};
      sonuc_q <= '0;
    end else begin
      val_q   <= val_d;
      op_q    <= op_d;
      etk_q   <= etk_d;
      sonuc_q <= sonuc_d;
    end
  end

  if (ASAMA == 1) begin : g_tek
    always_comb begin
      sonuc_d = sonuc_q;
      if (ilerle) begin
        sonuc_d = sec(carp(genislet(bus.deger1_i, isaretli1), genislet(bus.deger2_i, isaretli2)),
                      bus.kontrol_i);
      end
    end
  end else begin : g_cok
    logic [XLEN:0] a_q, a_d;
    logic [XLEN:0] b_q, b_d;

    // Stage 1 holds the extended operands; bubbles may overwrite them harmlessly.
    always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (ilerle) begin
        a_d = genislet(bus.deger1_i, isaretli1);
        b_d = genislet(bus.deger2_i, isaretli2);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end

    if (ASAMA == 2) begin : g_iki
      always_comb begin
        sonuc_d = sonuc_q;
        if (ilerle) begin
          sonuc_d = sec(carp(a_q, b_q), op_q[0]);
        end
      end
    end else begin : g_uzun
      logic [2*XLEN-1:0] car_q[ASAMA-2];
      logic [2*XLEN-1:0] car_d[ASAMA-2];

      // The full product is formed once, then carried until the result select before the output flop.
      always_comb begin
        car_d   = car_q;
        sonuc_d = sonuc_q;
        if (ilerle) begin
          car_d[0] = carp(a_q, b_q);
          for (int i = 1; i < ASAMA - 2; i++) begin
            car_d[i] = car_q[i-1];
          end
          sonuc_d = sec(car_q[ASAMA-3], op_q[ASAMA-2]);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          car_q <= '{default: '0};
        end else begin
          car_q <= car_d;
        end
      end
    end
  end

  assign bus.sonuc_o   = sonuc_q;
  assign bus.gecerli_o = val_q[ASAMA-1];
  assign bus.etiket_o  = etk_q[ASAMA-1];
  assign bus.mesgul_o  = |val_q;

endmodule

// File: tb/tb_carpma_birimi_hatli.sv
// Bench for carpma_birimi_hatli: directed scenarios plus randomized stall/flush traffic checked
// against an integer-arithmetic model and an in-flight queue of (result, tag, age) entries.
module tb_carpma_birimi_hatli;

  localparam int         ASAMA     = 3;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  carpma_birimi_hatli_if #(.XLEN(32), .ETIKET_W(5)) bus ();
  carpma_birimi_hatli_if #(.XLEN(64), .ETIKET_W(5)) bus64 ();

  carpma_birimi_hatli #(.XLEN(32), .ASAMA(ASAMA), .ETIKET_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  carpma_birimi_hatli #(.XLEN(64), .ASAMA(1), .ETIKET_W(5)) dut64 (
    .clk_i(clk), .rst_i(rst), .bus(bus64)
  );

  int passed = 0;
  int total  = 0;

  // Scoreboard: in-flight operations in issue order, with the count of advancing edges seen.
  logic [31:0] exp_q[$];
  logic [4:0]  etk_q[$];
  int          yas_q[$];
  logic [38:0] exp_vec;

  // Reference: extend per RISC-V rules, multiply as wide integers, pick the low or high word.
  function automatic logic [63:0] model(input int xlen, input logic [1:0] op,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [131:0] ea, eb, p, hi;
    logic [63:0] r;
    bit sa, sb;
    sa = (op != OP_MULHU);
    sb = (op == OP_MUL) || (op == OP_MULH);
    if (xlen == 32) begin
      if (sa) ea = $signed(a[31:0]); else ea = $signed({1'b0, a[31:0]});
      if (sb) eb = $signed(b[31:0]); else eb = $signed({1'b0, b[31:0]});
    end else begin
      if (sa) ea = $signed(a); else ea = $signed({1'b0, a});
      if (sb) eb = $signed(b); else eb = $signed({1'b0, b});
    end
    p  = ea * eb;
    hi = p >>> xlen;
    r  = (op == OP_MUL) ? p[63:0] : hi[63:0];
    if (xlen == 32) r[63:32] = 32'd0;
    return r;
  endfunction

  function automatic logic [31:0] rnd32();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h80000000;
      3:       v = 32'h7FFFFFFF;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  function automatic logic [38:0] gozlem();
    return {bus.gecerli_o, bus.mesgul_o,
            bus.gecerli_o ? bus.etiket_o : 5'd0,
            bus.gecerli_o ? bus.sonuc_o : 32'd0};
  endfunction

  // Driver: present one cycle of inputs, clock it, update the model, land #1 after the edge.
  task automatic step(input logic g, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t, input logic dur, input logic tem);
    logic hazir;
    bus.gecerli_i = g;  bus.kontrol_i = op; bus.deger1_i = a; bus.deger2_i = b;
    bus.etiket_i  = t;  bus.durdur_i  = dur; bus.temizle_i = tem;
    @(posedge clk);
    if (tem) begin
      exp_q.delete(); etk_q.delete(); yas_q.delete();
    end else if (!dur) begin
      if (yas_q.size() > 0 && yas_q[0] == ASAMA) begin
        void'(exp_q.pop_front()); void'(etk_q.pop_front()); void'(yas_q.pop_front());
      end
      foreach (yas_q[i]) yas_q[i]++;
      if (g) begin
        exp_q.push_back(model(32, op, {32'd0, a}, {32'd0, b}) & 64'hFFFFFFFF);
        etk_q.push_back(t);
        yas_q.push_back(1);
      end
    end
    #1;
    hazir   = (yas_q.size() > 0) && (yas_q[0] == ASAMA);
    exp_vec = {hazir, yas_q.size() > 0, hazir ? etk_q[0] : 5'd0, hazir ? exp_q[0] : 32'd0};
  endtask

  task automatic do_reset();
    bus.gecerli_i = 1'b0; bus.durdur_i = 1'b0; bus.temizle_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete(); etk_q.delete(); yas_q.delete();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.gecerli_o !== 1'b0) $display("FAIL reset_gecerli: got %b want 0", bus.gecerli_o); else passed++;
    total++; if (bus.mesgul_o !== 1'b0) $display("FAIL reset_mesgul: got %b want 0", bus.mesgul_o); else passed++;
    total++; if (bus.sonuc_o !== 32'd0) $display("FAIL reset_sonuc: got %h want 0", bus.sonuc_o); else passed++;
    total++; if (bus.etiket_o !== 5'd0) $display("FAIL reset_etiket: got %h want 0", bus.etiket_o); else passed++;
    total++; if (bus64.gecerli_o !== 1'b0 || bus64.sonuc_o !== 64'd0)
      $display("FAIL reset_dut64: got v=%b s=%h want 0/0", bus64.gecerli_o, bus64.sonuc_o); else passed++;
  endtask

  task automatic test_mul_basic();
    for (int i = 0; i < 5; i++) begin
      int c;
      c = i + 1;
      step(i == 0, OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b0, 1'b0);
      total++; if (gozlem() !== exp_vec) $display("FAIL mul_basic_model cyc%0d: got %h want %h", c, gozlem(), exp_vec); else passed++;
      total++; if (bus.mesgul_o !== (c <= 3)) $display("FAIL mul_basic_mesgul cyc%0d: got %b want %b", c, bus.mesgul_o, c <= 3); else passed++;
      if (c == 3) begin
        total++;
        if (bus.gecerli_o !== 1'b1 || bus.sonuc_o !== 32'hFFFFFFEB || bus.etiket_o !== 5'd5)
          $display("FAIL mul_basic_result: got v=%b s=%h t=%0d want 1/ffffffeb/5", bus.gecerli_o, bus.sonuc_o, bus.etiket_o);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops[3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] da[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bek[3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    for (int i = 0; i < 7; i++) begin
      int c, k;
      c = i + 1;
      k = (i < 3) ? i : 2;
      step(i < 3, ops[k], da[k], da[k], 5'(k + 1), 1'b0, 1'b0);
      total++; if (gozlem() !== exp_vec) $display("FAIL b2b_model cyc%0d: got %h want %h", c, gozlem(), exp_vec); else passed++;
      if (c >= 3 && c <= 5) begin
        total++;
        if (bus.gecerli_o !== 1'b1 || bus.sonuc_o !== bek[c-3] || bus.etiket_o !== 5'(c - 2))
          $display("FAIL b2b_result cyc%0d: got v=%b s=%h t=%0d want 1/%h/%0d", c, bus.gecerli_o, bus.sonuc_o, bus.etiket_o, bek[c-3], c - 2);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    logic [1:0]  ops[3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] da[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bek[3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int darbe = 0;
    for (int i = 0; i < 10; i++) begin
      int c, k;
      c = i + 1;
      k = (i < 2) ? i : 2;
      // Third op is held by the issuer across the stall and accepted once durdur_i drops.
      step(i <= 4, ops[k], da[k], da[k], 5'(k + 1), (i == 2) || (i == 3), 1'b0);
      total++; if (gozlem() !== exp_vec) $display("FAIL stall_model cyc%0d: got %h want %h", c, gozlem(), exp_vec); else passed++;
      if (bus.gecerli_o === 1'b1) darbe++;
      if (c >= 5 && c <= 7) begin
        total++;
        if (bus.gecerli_o !== 1'b1 || bus.sonuc_o !== bek[c-5])
          $display("FAIL stall_result cyc%0d: got v=%b s=%h want 1/%h", c, bus.gecerli_o, bus.sonuc_o, bek[c-5]);
        else passed++;
      end
    end
    total++; if (darbe != 3) $display("FAIL stall_pulses: got %0d want 3", darbe); else passed++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 8; i++) begin
      int c;
      c = i + 1;
      if (i == 3) step(1'b1, OP_MUL, 32'd3, 32'd4, 5'd9, 1'b0, 1'b0);
      else        step(i < 3, OP_MULH, 32'h12345678, 32'h9ABCDEF0, 5'(i), 1'b0, i == 2);
      total++; if (gozlem() !== exp_vec) $display("FAIL flush_model cyc%0d: got %h want %h", c, gozlem(), exp_vec); else passed++;
      if (c <= 5) begin
        total++; if (bus.gecerli_o !== 1'b0) $display("FAIL flush_killed cyc%0d: got %b want 0", c, bus.gecerli_o); else passed++;
      end
      if (c == 3) begin
        total++; if (bus.mesgul_o !== 1'b0) $display("FAIL flush_mesgul: got %b want 0", bus.mesgul_o); else passed++;
      end
      if (c == 6) begin
        total++;
        if (bus.gecerli_o !== 1'b1 || bus.sonuc_o !== 32'd12 || bus.etiket_o !== 5'd9)
          $display("FAIL flush_after: got v=%b s=%h t=%0d want 1/0000000c/9", bus.gecerli_o, bus.sonuc_o, bus.etiket_o);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, OP_MUL, 32'd1000, 32'd1000, 5'd17, 1'b0, 1'b0);
    do_reset();
    total++;
    if (bus.gecerli_o !== 1'b0 || bus.mesgul_o !== 1'b0 || bus.sonuc_o !== 32'd0 || bus.etiket_o !== 5'd0)
      $display("FAIL reset_mid_outputs: got v=%b m=%b s=%h t=%0d want all 0", bus.gecerli_o, bus.mesgul_o, bus.sonuc_o, bus.etiket_o);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      total++; if (bus.gecerli_o !== 1'b0 || gozlem() !== exp_vec)
        $display("FAIL reset_mid_lost step%0d: got %h want %h", i, gozlem(), exp_vec); else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic g, dur, tem;
      g   = ($urandom_range(0, 9) < 7);
      dur = ($urandom_range(0, 9) < 2);
      tem = ($urandom_range(0, 39) == 0);
      step(g, 2'($urandom_range(0, 3)), rnd32(), rnd32(), 5'($urandom()), dur, tem);
      total++; if (gozlem() !== exp_vec) $display("FAIL random_model step%0d: got %h want %h", i, gozlem(), exp_vec); else passed++;
    end
    for (int i = 0; i < ASAMA + 1; i++) begin
      step(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      total++; if (gozlem() !== exp_vec) $display("FAIL random_drain step%0d: got %h want %h", i, gozlem(), exp_vec); else passed++;
    end
    total++; if (bus.mesgul_o !== 1'b0) $display("FAIL random_idle_mesgul: got %b want 0", bus.mesgul_o); else passed++;
  endtask

  task automatic test_xlen64();
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [63:0] a, b, bek;
      logic [4:0]  t;
      t = 5'($urandom());
      if (i == 0)      begin op = OP_MULHU; a = '1; b = 64'd2; bek = 64'd1; end
      else if (i == 1) begin op = OP_MUL;   a = '1; b = 64'd2; bek = 64'hFFFFFFFFFFFFFFFE; end
      else begin
        op = 2'($urandom_range(0, 3));
        a = {rnd32(), rnd32()};
        b = {rnd32(), rnd32()};
        bek = model(64, op, a, b);
      end
      bus64.gecerli_i = 1'b1; bus64.kontrol_i = op; bus64.deger1_i = a; bus64.deger2_i = b; bus64.etiket_i = t;
      @(posedge clk);
      #1;
      total++;
      if (bus64.gecerli_o !== 1'b1 || bus64.sonuc_o !== bek || bus64.etiket_o !== t)
        $display("FAIL x64_result step%0d: got v=%b s=%h t=%0d want 1/%h/%0d", i, bus64.gecerli_o, bus64.sonuc_o, bus64.etiket_o, bek, t);
      else passed++;
    end
    bus64.gecerli_i = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus64.gecerli_o !== 1'b0 || bus64.mesgul_o !== 1'b0)
      $display("FAIL x64_idle: got v=%b m=%b want 0/0", bus64.gecerli_o, bus64.mesgul_o); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bus.gecerli_i = 1'b0; bus.durdur_i = 1'b0; bus.temizle_i = 1'b0; bus.kontrol_i = OP_MUL;
    bus.deger1_i = '0; bus.deger2_i = '0; bus.etiket_i = '0;
    bus64.gecerli_i = 1'b0; bus64.durdur_i = 1'b0; bus64.temizle_i = 1'b0; bus64.kontrol_i = OP_MUL;
    bus64.deger1_i = '0; bus64.deger2_i = '0; bus64.etiket_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_mul_basic();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    test_xlen64();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
